// File: rtl/jtkcpu_pshpul.sv
// jtkcpu_pshpul: stack push/pull sequencer for PSH/PUL postbytes.
// Turns a register mask into one stack byte access at a time, tracks the
// working stack pointer and rebuilds pulled bytes into register loads.
// Optional build macro: JTKCPU_PSHPUL_NOSP_EN. When defined, pulls ignore
// mask bit 6 (U/S), so the stack pointer is never reloaded from the stack.
module jtkcpu_pshpul #(
    parameter logic [15:0] SPRST = 16'h0000
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        psh_go,
    input  logic        pul_go,
    input  logic [7:0]  mask,
    input  logic [15:0] sp_in,
    input  logic [7:0]  cc,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [7:0]  dp,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] uo,
    input  logic [15:0] pc,
    input  logic        ack,
    input  logic [7:0]  rd_data,
    output logic [15:0] psh_addr,
    output logic        psh_dec,
    output logic        pul_rd,
    output logic [7:0]  psh_mux,
    output logic        ld,
    output logic [7:0]  ld_sel,
    output logic [15:0] ld_data,
    output logic [15:0] sp_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, PUSH, PULL, DONE} state_t;

    state_t      st, st_nx;
    logic [7:0]  rem;       // registers still to be transferred
    logic        ph;        // second byte of a 16-bit register
    logic [7:0]  hi;        // high byte held while pulling a 16-bit register
    logic [7:0]  pul_mask;
    logic [7:0]  cur;       // one-hot register being transferred
    logic        wide;
    logic        last;
    logic [15:0] psh_word;
    logic [7:0]  psh_byte;

    // Pushes run from PC downwards, so the highest pending bit goes first
    function automatic logic [7:0] first_hi(input logic [7:0] m);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Pulls run from CC upwards, so the lowest pending bit goes first
    function automatic logic [7:0] first_lo(input logic [7:0] m);
        logic [7:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

`ifdef JTKCPU_PSHPUL_NOSP_EN
    assign pul_mask = {mask[7], 1'b0, mask[5:0]};
`else
    assign pul_mask = mask;
`endif

    assign cur  = (st == PUSH) ? first_hi(rem) : first_lo(rem);
    assign wide = |cur[7:4];
    assign last = ((rem & ~cur) == 8'h00) && (!wide || ph);

    // Register value for the byte currently being pushed
    always_comb begin
        case (cur)
            8'h80:   psh_word = pc;
            8'h40:   psh_word = uo;
            8'h20:   psh_word = y;
            8'h10:   psh_word = x;
            8'h08:   psh_word = {8'h00, dp};
            8'h04:   psh_word = {8'h00, b};
            8'h02:   psh_word = {8'h00, a};
            default: psh_word = {8'h00, cc};
        endcase
    end

    // Pushes send the low byte of a 16-bit register first
    assign psh_byte = (wide && ph) ? psh_word[15:8] : psh_word[7:0];

    assign busy = (st != IDLE);
    assign done = (st == DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      st <= IDLE;
        else if (cen) st <= st_nx;
    end

    // Next state and memory request outputs
    always_comb begin
        st_nx    = st;
        psh_dec  = 1'b0;
        pul_rd   = 1'b0;
        psh_addr = 16'h0000;
        psh_mux  = 8'h00;
        case (st)
            IDLE: begin
                if (psh_go)      st_nx = (mask != 8'h00) ? PUSH : DONE;
                else if (pul_go) st_nx = (pul_mask != 8'h00) ? PULL : DONE;
            end
            PUSH: begin
                psh_dec  = 1'b1;
                psh_addr = sp_out;
                psh_mux  = psh_byte;
                if (ack && last) st_nx = DONE;
            end
            PULL: begin
                pul_rd   = 1'b1;
                psh_addr = sp_out;
                if (ack && last) st_nx = DONE;
            end
            default: st_nx = IDLE;
        endcase
    end

    // Stack pointer, byte bookkeeping and register load strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_out  <= SPRST;
            rem     <= 8'h00;
            ph      <= 1'b0;
            hi      <= 8'h00;
            ld      <= 1'b0;
            ld_sel  <= 8'h00;
            ld_data <= 16'h0000;
        end else if (cen) begin
            ld <= 1'b0;
            case (st)
                IDLE: begin
                    if (psh_go || pul_go) begin
                        rem    <= psh_go ? mask : pul_mask;
                        ph     <= 1'b0;
                        sp_out <= sp_in;
                    end
                end
                PUSH: begin
                    if (ack) begin
                        sp_out <= sp_out - 16'd1;
                        if (wide && !ph) begin
                            ph <= 1'b1;
                        end else begin
                            ph  <= 1'b0;
                            rem <= rem & ~cur;
                        end
                    end
                end
                PULL: begin
                    if (ack) begin
                        sp_out <= sp_out + 16'd1;
                        if (wide && !ph) begin
                            hi <= rd_data;
                            ph <= 1'b1;
                        end else begin
                            ph      <= 1'b0;
                            rem     <= rem & ~cur;
                            ld      <= 1'b1;
                            ld_sel  <= cur;
                            ld_data <= wide ? {hi, rd_data} : {8'h00, rd_data};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/jtkcpu_pshpul.md
Name: jtkcpu_pshpul

Overview:
- Stack push/pull sequencer. Sits directly upstream of the memory controller.
- Converts a PSH/PUL postbyte register mask into a byte-by-byte sequence of stack accesses: stack address, push-decrement flag and push data byte.
- On pulls, reassembles returned bytes into register load strobes.
- Maintains the working stack pointer (S or U) across the whole instruction.

Parameters:
- SPRST, 16'h0000, reset value of the internal working stack pointer

Ports:
- rst  in  1  asynchronous reset, active high
- clk  in  1  system clock
- cen  in  1  CPU clock enable; all state advances only when cen=1
- psh_go  in  1  one-cycle start pulse, push sequence
- pul_go  in  1  one-cycle start pulse, pull sequence
- mask  in  8  postbyte: b7 PC, b6 U/S, b5 Y, b4 X, b3 DP, b2 B, b1 A, b0 CC
- sp_in  in  16  stack pointer value, sampled on go
- cc, a, b, dp  in  8 each  register values for push
- x, y, uo, pc  in  16 each  register values for push (uo = the other stack pointer)
- ack  in  1  memory access completed; for pulls, rd_data is valid this cycle
- rd_data  in  8  byte read from memory
- psh_addr  out  16  stack address to memory controller
- psh_dec  out  1  push byte request (memory writes at psh_addr-1)
- pul_rd  out  1  pull byte request (memory reads at psh_addr)
- psh_mux  out  8  byte to be pushed
- ld  out  1  one-cycle register load strobe
- ld_sel  out  8  one-hot register select, same bit map as mask
- ld_data  out  16  load value; 8-bit registers in [7:0], [15:8]=0
- sp_out  out  16  working stack pointer
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Reset: psh_addr=0, psh_dec=0, pul_rd=0, psh_mux=0, ld=0, ld_sel=0, ld_data=0, sp_out=SPRST, busy=0, done=0. State = IDLE.
- States: IDLE, PUSH, PULL, DONE.
- IDLE:
  - psh_go with mask!=0: latch mask, sp_out<=sp_in, go to PUSH.
  - pul_go with mask!=0: same latching, go to PULL.
  - mask==0: go straight to DONE; sp unchanged; no memory request.
  - psh_go and pul_go together: push wins.
  - go while busy: ignored.
- PUSH byte order: PCl, PCh, Ul, Uh, Yl, Yh, Xl, Xh, DP, B, A, CC. Only masked registers are pushed.
  - Each byte holds psh_dec=1, psh_addr=sp_out, psh_mux=byte until ack.
  - On ack: sp_out<=sp_out-1, advance to the next byte.
  - The next request is presented in the cycle after ack.
- PULL byte order: CC, A, B, DP, Xh, Xl, Yh, Yl, Uh, Ul, PCh, PCl.
  - Each byte holds pul_rd=1, psh_addr=sp_out until ack.
  - On ack: sp_out<=sp_out+1.
  - 8-bit register: ld pulses the cycle after ack with ld_data={8'h0,rd_data}.
  - 16-bit register: high byte is latched internally; ld pulses after the low-byte ack with the full word.
- Last byte acked: clear requests, go to DONE. DONE pulses done=1 for one cen cycle, then returns to IDLE.
- busy=1 from the cycle after go until DONE inclusive.
- sp_out arithmetic is 16-bit modulo: 0x0000-1=0xFFFF, 0xFFFF+1=0x0000.
- Byte count: push/pull of all registers = 12 bytes. sp_out changes by exactly the number of masked bytes.
- ack with no request pending: ignored.
- ack when cen=0: ignored. The memory controller must hold ack until sampled on a cen cycle.
- Reset mid-sequence: immediate return to reset values; no partial ld is issued afterwards.

Optional Feature:
- Macro JTKCPU_PSHPUL_NOSP_EN.
- When defined, the mask bit b6 (U/S) is forced to 0 on pulls: the stack pointer is never reloaded from the stack and those 2 bytes are skipped.
- When undefined, b6 is honoured like any other mask bit.

Test Plan:
- Push mask=0x06 (A,B), sp_in=0x1000, A=0x11, B=0x22, ack each cycle -> psh_mux 0x22 at addr 0x1000, then 0x11 at 0x0FFF; sp_out=0x0FFE; done once.
- Pull mask=0x90 (X,PC), sp=0x0FF0, rd_data 0x12,0x34,0x56,0x78 -> ld_sel=0x10 with ld_data=0x1234, then ld_sel=0x80 with 0x5678; sp_out=0x0FF4.
- mask=0x00 push -> no psh_dec, done one cycle later, sp_out=sp_in.
- Push mask=0xFF, sp_in=0x0003 -> 12 writes, addresses wrap 0x0003..0xFFF8, sp_out=0xFFF7.
- Pull with ack delayed 3 cycles per byte, cen toggling every other clk -> same ld values, pul_rd held steady while waiting.
- Reset asserted after 2nd push byte -> all outputs return to reset values, busy=0, no done pulse.
